// File: rtl/data_write_ctrl.sv
// Serial-to-parallel sample writer for the MSDAP input store: assembles MSB-first
// 16-bit words, writes them at a wrapping pointer, and tracks flush, framing and zero-run sleep.
module data_write_ctrl #(
    parameter int DATA_WIDTH   = 16,
    parameter int ADDR_WIDTH   = 8,
    parameter int FLUSH_CYCLES = 770,
    parameter int ZERO_LIMIT   = 800
) (
    input  logic                  sClk,
    input  logic                  memReset_n,
    input  logic                  serialIn,
    input  logic                  bitValid,
    input  logic                  frameSync,
    output logic                  writeEnable,
    output logic [ADDR_WIDTH-1:0] dataWriteAddr,
    output logic [DATA_WIDTH-1:0] dataValueIn,
    output logic [ADDR_WIDTH-1:0] newestAddr,
    output logic                  sampleReady,
    output logic                  sleepFlag,
    output logic                  flushBusy,
    output logic                  frameError
);

    localparam int CNT_W = $clog2(DATA_WIDTH + 1);
    localparam int FL_W  = $clog2(FLUSH_CYCLES + 1);
    localparam int ZC_W  = $clog2(ZERO_LIMIT + 1);

    localparam logic [1:0] FLUSH_WAIT = 2'd0;
    localparam logic [1:0] IDLE       = 2'd1;
    localparam logic [1:0] SHIFT      = 2'd2;
    localparam logic [1:0] WRITE      = 2'd3;

    localparam logic [FL_W-1:0]  FLUSH_LAST = FL_W'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] FIRST_BIT  = CNT_W'(1);
    localparam logic [ZC_W-1:0]  ZERO_MAX   = ZC_W'(ZERO_LIMIT);
    localparam logic [ZC_W-1:0]  ZERO_NEAR  = ZC_W'(ZERO_LIMIT - 1);

    logic [1:0]            state_q,     state_d;
    logic [FL_W-1:0]       flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0]      bit_cnt_q,   bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,     shift_d;
    logic [ADDR_WIDTH-1:0] wr_ptr_q,    wr_ptr_d;
    logic [ZC_W-1:0]       zero_cnt_q,  zero_cnt_d;
    logic                  we_q,        we_d;
    logic [ADDR_WIDTH-1:0] addr_q,      addr_d;
    logic [DATA_WIDTH-1:0] data_q,      data_d;
    logic [ADDR_WIDTH-1:0] newest_q,    newest_d;
    logic                  ready_q,     ready_d;
    logic                  sleep_q,     sleep_d;
    logic                  busy_q,      busy_d;
    logic                  ferr_q,      ferr_d;

    logic                  start_s;
    logic [DATA_WIDTH-1:0] first_word_s;

    assign start_s      = bitValid & frameSync;
    assign first_word_s = {{(DATA_WIDTH-1){1'b0}}, serialIn};

    // Next-state logic: frame FSM plus the commit stage that follows each write strobe
    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        wr_ptr_d    = wr_ptr_q;
        zero_cnt_d  = zero_cnt_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        newest_d    = newest_q;
        ready_d     = 1'b0;
        sleep_d     = sleep_q;
        busy_d      = busy_q;
        ferr_d      = ferr_q;

        case (state_q)
            FLUSH_WAIT: begin
                if (flush_cnt_q == FLUSH_LAST) begin
                    state_d     = IDLE;
                    busy_d      = 1'b0;
                    flush_cnt_d = '0;
                end else begin
                    flush_cnt_d = flush_cnt_q + FL_W'(1);
                end
            end
            // WRITE also runs the IDLE start check so a back-to-back MSB is not lost
            IDLE, WRITE: begin
                if (state_q == WRITE) begin
                    we_d   = 1'b1;
                    addr_d = wr_ptr_q;
                    data_d = shift_q;
                end else begin
                    we_d   = 1'b0;
                end
                if (start_s) begin
                    shift_d   = first_word_s;
                    bit_cnt_d = FIRST_BIT;
                    state_d   = SHIFT;
                end else begin
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end
            end
            SHIFT: begin
                if (bitValid) begin
                    if (frameSync) begin
                        ferr_d    = 1'b1;
                        shift_d   = first_word_s;
                        bit_cnt_d = FIRST_BIT;
                    end else begin
                        shift_d   = {shift_q[DATA_WIDTH-2:0], serialIn};
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
                            state_d = WRITE;
                        end else begin
                            state_d = SHIFT;
                        end
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            default: begin
                state_d = FLUSH_WAIT;
            end
        endcase

        // The cycle after the strobe publishes the write and updates the zero run
        if (we_q) begin
            ready_d  = 1'b1;
            newest_d = wr_ptr_q;
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
            if (data_q == '0) begin
                if (zero_cnt_q >= ZERO_NEAR) begin
                    zero_cnt_d = ZERO_MAX;
                    sleep_d    = 1'b1;
                end else begin
                    zero_cnt_d = zero_cnt_q + ZC_W'(1);
                    sleep_d    = sleep_q;
                end
            end else begin
                zero_cnt_d = '0;
                sleep_d    = 1'b0;
            end
        end else begin
            ready_d = 1'b0;
        end
    end

    // State and output registers, cleared asynchronously
    always_ff @(posedge sClk or negedge memReset_n) begin
        if (!memReset_n) begin
            state_q     <= FLUSH_WAIT;
            flush_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            wr_ptr_q    <= '0;
            zero_cnt_q  <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            newest_q    <= {ADDR_WIDTH{1'b1}};
            ready_q     <= 1'b0;
            sleep_q     <= 1'b0;
            busy_q      <= 1'b1;
            ferr_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            wr_ptr_q    <= wr_ptr_d;
            zero_cnt_q  <= zero_cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            newest_q    <= newest_d;
            ready_q     <= ready_d;
            sleep_q     <= sleep_d;
            busy_q      <= busy_d;
            ferr_q      <= ferr_d;
        end
    end

    assign writeEnable   = we_q;
    assign dataWriteAddr = addr_q;
    assign dataValueIn   = data_q;
    assign newestAddr    = newest_q;
    assign sampleReady   = ready_q;
    assign sleepFlag     = sleep_q;
    assign flushBusy     = busy_q;
    assign frameError    = ferr_q;

endmodule
